// File: rtl/door_lockout.sv
// Keypad door controller: counts consecutive failed attempts, locks out after
// MAX_FAIL failures for LOCK_CYCLES cycles with a blinking red indication.
module door_lockout #(
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 20,
    parameter int unsigned BLINK_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       match,
    input  logic       admin_override,
    output logic       door_open,
    output logic       red_LED,
    output logic       lock_active,
    output logic [2:0] fail_count,
    output logic [7:0] lock_remaining
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] OPEN   = 2'd1;
    localparam logic [1:0] DENIED = 2'd2;
    localparam logic [1:0] LOCKED = 2'd3;

    localparam logic [3:0] MAX_FAIL_W = 4'(MAX_FAIL);
    localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);
    localparam logic [7:0] LOCK_LOAD  = 8'(LOCK_CYCLES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

    logic [1:0] state;
    logic [1:0] state_n;
    logic       enter_q;
    logic       armed;
    logic       attempt;
    logic [2:0] fail_n;
    logic [3:0] fail_inc;
    logic [7:0] rem_n;
    logic [7:0] blink_cnt;
    logic [7:0] blink_cnt_n;
    logic       blink;
    logic       blink_n;

    // enter_q alone would see a held button as a fresh edge right after reset;
    // armed requires enter to have been seen low since reset before any edge counts.
    assign attempt  = enter & ~enter_q & armed;
    assign fail_inc = {1'b0, fail_count} + 4'd1;

    always_comb begin
        state_n     = state;
        fail_n      = fail_count;
        rem_n       = lock_remaining;
        blink_cnt_n = blink_cnt;
        blink_n     = blink;
        if (admin_override) begin
            state_n     = IDLE;
            fail_n      = '0;
            rem_n       = '0;
            blink_cnt_n = '0;
            blink_n     = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (attempt) begin
                        if (match) begin
                            state_n = OPEN;
                            fail_n  = '0;
                        end else if (fail_inc >= MAX_FAIL_W) begin
                            state_n     = LOCKED;
                            fail_n      = MAX_FAIL_C;
                            rem_n       = LOCK_LOAD;
                            blink_cnt_n = '0;
                            blink_n     = 1'b1;
                        end else begin
                            state_n = DENIED;
                            fail_n  = fail_inc[2:0];
                        end
                    end
                end
                OPEN, DENIED: begin
                    if (!enter) state_n = IDLE;
                end
                LOCKED: begin
                    if (lock_remaining == '0) begin
                        state_n     = IDLE;
                        fail_n      = '0;
                        blink_cnt_n = '0;
                        blink_n     = 1'b0;
                    end else begin
                        rem_n = lock_remaining - 8'd1;
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt_n = '0;
                            blink_n     = ~blink;
                        end else begin
                            blink_cnt_n = blink_cnt + 8'd1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state values so they change together with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            enter_q        <= 1'b0;
            armed          <= 1'b0;
            fail_count     <= '0;
            lock_remaining <= '0;
            blink_cnt      <= '0;
            blink          <= 1'b0;
            door_open      <= 1'b0;
            red_LED        <= 1'b0;
            lock_active    <= 1'b0;
        end else begin
            state          <= state_n;
            enter_q        <= enter;
            armed          <= armed | ~enter;
            fail_count     <= fail_n;
            lock_remaining <= rem_n;
            blink_cnt      <= blink_cnt_n;
            blink          <= blink_n;
            door_open      <= (state_n == OPEN);
            red_LED        <= (state_n == DENIED) | ((state_n == LOCKED) & blink_n);
            lock_active    <= (state_n == LOCKED);
        end
    end

endmodule
